// File: rtl/bp_sound_mailbox.sv
// bp_sound_mailbox: main-to-sound command mailbox with NMI sequencing and DIP echo.
// Define BP_SNDCMD_FIFO_EN for the queued/gap mode; otherwise a single latch.
module bp_sound_mailbox #(
  parameter int FIFO_DEPTH = 4,
  parameter int NMI_GAP = 8
) (
  input  logic       clk_49m,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_wr,
  input  logic       snd_rd,
  output logic [7:0] snd_cmd,
  output logic       snd_nmi_n,
  output logic       cmd_pending,
  output logic       cmd_overflow,
  input  logic [7:0] dip_default,
  input  logic       snd_dip_wr,
  input  logic [7:0] snd_dip_data,
  output logic [7:0] dipsw_readback,
  output logic       dip_valid
);
  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;
  state_t r_state, w_next;
  logic [7:0] r_snd_cmd, w_snd_cmd, r_dip;
  logic r_nmi_n, r_pend, r_ovf, w_ovf, r_dip_valid;
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      r_state <= IDLE;
      r_snd_cmd <= 8'h00;
      r_nmi_n <= 1'b1;
      r_pend <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_next;
      r_snd_cmd <= w_snd_cmd;
      r_nmi_n <= w_next != ASSERT;
      r_pend <= w_next == ASSERT;
      r_ovf <= r_ovf | w_ovf;
    end
  end
`ifdef BP_SNDCMD_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic [7:0] r_next, r_gap, w_head;
  logic w_has, w_rd, w_pop, w_byp, w_push;
  // r_next stages the head popped at the read, so the freed slot can take a
  // same-cycle write while snd_cmd stays put until the gap expires.
  assign w_head = r_mem[r_rp];
  assign w_has = r_cnt != '0;
  assign w_rd = r_state == ASSERT && snd_rd;
  assign w_pop = w_has && (r_state == IDLE || w_rd);
  assign w_byp = cmd_wr && !w_has && (r_state == IDLE || w_rd);
  assign w_push = cmd_wr && !w_byp && (r_cnt != (AW+1)'(FIFO_DEPTH) || w_pop);
  assign w_ovf = cmd_wr && !w_byp && !w_push;
  always_comb begin
    w_next = r_state;
    w_snd_cmd = r_snd_cmd;
    if (r_state == IDLE && (w_has || cmd_wr)) begin
      w_next = ASSERT;
      w_snd_cmd = w_has ? w_head : cmd_data;
    end else if (w_rd) begin
      w_next = (w_has || cmd_wr) ? GAP : IDLE;
    end else if (r_state == GAP && r_gap == 8'd0) begin
      w_next = ASSERT;
      w_snd_cmd = r_next;
    end
  end
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_next <= 8'h00;
      r_gap <= 8'h00;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= cmd_data;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_rd) begin
        r_next <= w_has ? w_head : cmd_data;
        r_gap <= 8'(NMI_GAP - 1);
      end else if (r_state == GAP) begin
        r_gap <= r_gap - 8'd1;
      end
    end
  end
`else
  logic [7:0] w_unused;
  assign w_unused = 8'(FIFO_DEPTH) ^ 8'(NMI_GAP);
  // A write on top of an unread command overwrites it; a write together with
  // the read is a fresh command, so it is not counted as an overflow.
  assign w_ovf = cmd_wr && r_state == ASSERT && !snd_rd;
  always_comb begin
    w_next = r_state;
    w_snd_cmd = r_snd_cmd;
    if (cmd_wr) begin
      w_next = ASSERT;
      w_snd_cmd = cmd_data;
    end else if (r_state == ASSERT && snd_rd) begin
      w_next = IDLE;
    end
  end
`endif
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      r_dip <= 8'h00;
      r_dip_valid <= 1'b0;
    end else if (snd_dip_wr) begin
      r_dip <= snd_dip_data;
      r_dip_valid <= 1'b1;
    end
  end
  assign snd_cmd = r_snd_cmd;
  assign snd_nmi_n = r_nmi_n;
  assign cmd_pending = r_pend;
  assign cmd_overflow = r_ovf;
  assign dip_valid = r_dip_valid;
  assign dipsw_readback = r_dip_valid ? r_dip : dip_default;
endmodule

// File: tb/tb_bp_sound_mailbox.sv
// tb_bp_sound_mailbox: directed self-checking bench for bp_sound_mailbox (both build modes).
module tb_bp_sound_mailbox;
  logic clk_49m = 1'b0, reset = 1'b1, cmd_wr = 1'b0, snd_rd = 1'b0, snd_dip_wr = 1'b0;
  logic [7:0] cmd_data = 8'h00, dip_default = 8'hA5, snd_dip_data = 8'h00;
  logic [7:0] snd_cmd, dipsw_readback;
  logic snd_nmi_n, cmd_pending, cmd_overflow, dip_valid;
  int total = 0, bad = 0;

  always #5 clk_49m = ~clk_49m;

  bp_sound_mailbox #(.FIFO_DEPTH(4), .NMI_GAP(8)) dut (
    .clk_49m(clk_49m), .reset(reset), .cmd_data(cmd_data), .cmd_wr(cmd_wr),
    .snd_rd(snd_rd), .snd_cmd(snd_cmd), .snd_nmi_n(snd_nmi_n),
    .cmd_pending(cmd_pending), .cmd_overflow(cmd_overflow),
    .dip_default(dip_default), .snd_dip_wr(snd_dip_wr), .snd_dip_data(snd_dip_data),
    .dipsw_readback(dipsw_readback), .dip_valid(dip_valid)
  );

  task automatic tick;
    @(posedge clk_49m);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    cmd_data = d;
    cmd_wr = 1'b1;
    tick();
    cmd_wr = 1'b0;
  endtask

  task automatic rd;
    snd_rd = 1'b1;
    tick();
    snd_rd = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    total++; if (snd_nmi_n !== 1'b1) begin bad++; $display("FAIL reset_nmi got=%b want=1", snd_nmi_n); end
    total++; if (snd_cmd !== 8'h00) begin bad++; $display("FAIL reset_cmd got=%h want=00", snd_cmd); end
    total++; if (cmd_pending !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b want=0", cmd_pending); end
    total++; if (cmd_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", cmd_overflow); end
    total++; if (dip_valid !== 1'b0) begin bad++; $display("FAIL reset_dipv got=%b want=0", dip_valid); end
    total++; if (dipsw_readback !== 8'hA5) begin bad++; $display("FAIL reset_dip got=%h want=a5", dipsw_readback); end
    dip_default = 8'h5A;
    #1;
    total++; if (dipsw_readback !== 8'h5A) begin bad++; $display("FAIL dip_pass got=%h want=5a", dipsw_readback); end
    dip_default = 8'hA5;
  endtask

  task automatic test_single;
    int lo;
    repeat (4) tick();
    wr(8'h12);
    total++; if (snd_cmd !== 8'h12) begin bad++; $display("FAIL single_cmd got=%h want=12", snd_cmd); end
    total++; if (snd_nmi_n !== 1'b0) begin bad++; $display("FAIL single_nmi got=%b want=0", snd_nmi_n); end
    total++; if (cmd_pending !== 1'b1) begin bad++; $display("FAIL single_pend got=%b want=1", cmd_pending); end
    repeat (13) tick();
    total++; if (snd_nmi_n !== 1'b0) begin bad++; $display("FAIL single_hold got=%b want=0", snd_nmi_n); end
    rd();
    total++; if (snd_nmi_n !== 1'b1) begin bad++; $display("FAIL single_rel got=%b want=1", snd_nmi_n); end
    total++; if (cmd_pending !== 1'b0) begin bad++; $display("FAIL single_pclr got=%b want=0", cmd_pending); end
    lo = 0;
    repeat (10) begin tick(); if (!snd_nmi_n) lo++; end
    total++; if (lo !== 0) begin bad++; $display("FAIL single_quiet got=%0d want=0", lo); end
    rd();
    total++; if (snd_cmd !== 8'h12 || snd_nmi_n !== 1'b1) begin bad++; $display("FAIL idle_rd got=%h/%b want=12/1", snd_cmd, snd_nmi_n); end
    total++; if (cmd_overflow !== 1'b0) begin bad++; $display("FAIL single_ovf got=%b want=0", cmd_overflow); end
  endtask

`ifdef BP_SNDCMD_FIFO_EN
  task automatic test_sequence;
    logic [7:0] exp [3] = '{8'h01, 8'h02, 8'h03};
    int hi, lo;
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    for (int i = 0; i < 3; i++) begin
      hi = 0;
      while (snd_nmi_n && hi < 200) begin hi++; tick(); end
      total++; if (hi !== (i == 0 ? 0 : 8)) begin bad++; $display("FAIL seq_gap%0d got=%0d want=%0d", i, hi, i == 0 ? 0 : 8); end
      total++; if (snd_cmd !== exp[i]) begin bad++; $display("FAIL seq_cmd%0d got=%h want=%h", i, snd_cmd, exp[i]); end
      tick();
      tick();
      total++; if (snd_nmi_n !== 1'b0 || snd_cmd !== exp[i]) begin bad++; $display("FAIL seq_hold%0d got=%b/%h want=0/%h", i, snd_nmi_n, snd_cmd, exp[i]); end
      rd();
    end
    lo = 0;
    repeat (20) begin tick(); if (!snd_nmi_n) lo++; end
    total++; if (lo !== 0) begin bad++; $display("FAIL seq_quiet got=%0d want=0", lo); end
    total++; if (cmd_overflow !== 1'b0) begin bad++; $display("FAIL seq_ovf got=%b want=0", cmd_overflow); end
  endtask

  task automatic test_overflow;
    int hi, lo;
    for (int k = 0; k < 6; k++) begin
      wr(8'(8'h51 + k));
      if (k == 4) begin
        total++; if (cmd_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", cmd_overflow); end
      end
    end
    total++; if (cmd_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", cmd_overflow); end
    for (int i = 0; i < 5; i++) begin
      hi = 0;
      while (snd_nmi_n && hi < 200) begin hi++; tick(); end
      total++; if (snd_cmd !== 8'(8'h51 + i)) begin bad++; $display("FAIL ovf_cmd%0d got=%h want=%h", i, snd_cmd, 8'(8'h51 + i)); end
      rd();
    end
    lo = 0;
    repeat (30) begin tick(); if (!snd_nmi_n) lo++; end
    total++; if (lo !== 0) begin bad++; $display("FAIL ovf_extra got=%0d want=0", lo); end
    total++; if (cmd_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", cmd_overflow); end
  endtask

  task automatic test_full_rw;
    logic [7:0] exp [5] = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h44};
    int hi, lo;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) wr(8'(8'h61 + k));
    tick();
    tick();
    cmd_data = 8'h44;
    cmd_wr = 1'b1;
    snd_rd = 1'b1;
    tick();
    cmd_wr = 1'b0;
    snd_rd = 1'b0;
    total++; if (cmd_overflow !== 1'b0) begin bad++; $display("FAIL frw_ovf got=%b want=0", cmd_overflow); end
    total++; if (snd_nmi_n !== 1'b1) begin bad++; $display("FAIL frw_rel got=%b want=1", snd_nmi_n); end
    for (int i = 0; i < 5; i++) begin
      hi = 0;
      while (snd_nmi_n && hi < 200) begin hi++; tick(); end
      total++; if (hi !== 8) begin bad++; $display("FAIL frw_gap%0d got=%0d want=8", i, hi); end
      total++; if (snd_cmd !== exp[i]) begin bad++; $display("FAIL frw_cmd%0d got=%h want=%h", i, snd_cmd, exp[i]); end
      tick();
      rd();
    end
    lo = 0;
    repeat (20) begin tick(); if (!snd_nmi_n) lo++; end
    total++; if (lo !== 0) begin bad++; $display("FAIL frw_quiet got=%0d want=0", lo); end
    total++; if (cmd_overflow !== 1'b0) begin bad++; $display("FAIL frw_ovf_end got=%b want=0", cmd_overflow); end
  endtask
`else
  task automatic test_latch;
    wr(8'h21);
    total++; if (snd_cmd !== 8'h21 || snd_nmi_n !== 1'b0) begin bad++; $display("FAIL latch_first got=%h/%b want=21/0", snd_cmd, snd_nmi_n); end
    tick();
    total++; if (snd_nmi_n !== 1'b0) begin bad++; $display("FAIL latch_hold got=%b want=0", snd_nmi_n); end
    wr(8'h22);
    total++; if (snd_cmd !== 8'h22) begin bad++; $display("FAIL latch_over got=%h want=22", snd_cmd); end
    total++; if (snd_nmi_n !== 1'b0 || cmd_pending !== 1'b1) begin bad++; $display("FAIL latch_low got=%b/%b want=0/1", snd_nmi_n, cmd_pending); end
    total++; if (cmd_overflow !== 1'b1) begin bad++; $display("FAIL latch_ovf got=%b want=1", cmd_overflow); end
    rd();
    total++; if (snd_nmi_n !== 1'b1) begin bad++; $display("FAIL latch_rel got=%b want=1", snd_nmi_n); end
    tick();
    wr(8'h23);
    total++; if (snd_cmd !== 8'h23 || snd_nmi_n !== 1'b0) begin bad++; $display("FAIL latch_next got=%h/%b want=23/0", snd_cmd, snd_nmi_n); end
    total++; if (cmd_overflow !== 1'b1) begin bad++; $display("FAIL latch_sticky got=%b want=1", cmd_overflow); end
    rd();
  endtask
`endif

  task automatic test_dip_reset;
    int lo;
    snd_dip_data = 8'h3C;
    snd_dip_wr = 1'b1;
    tick();
    snd_dip_wr = 1'b0;
    total++; if (dipsw_readback !== 8'h3C) begin bad++; $display("FAIL dip_echo got=%h want=3c", dipsw_readback); end
    total++; if (dip_valid !== 1'b1) begin bad++; $display("FAIL dip_valid got=%b want=1", dip_valid); end
    dip_default = 8'h00;
    #1;
    total++; if (dipsw_readback !== 8'h3C) begin bad++; $display("FAIL dip_latched got=%h want=3c", dipsw_readback); end
    wr(8'h71);
    wr(8'h72);
    wr(8'h73);
    total++; if (snd_nmi_n !== 1'b0) begin bad++; $display("FAIL rst_pre got=%b want=0", snd_nmi_n); end
    reset = 1'b1;
    tick();
    total++; if (snd_nmi_n !== 1'b1) begin bad++; $display("FAIL rst_nmi got=%b want=1", snd_nmi_n); end
    total++; if (dip_valid !== 1'b0) begin bad++; $display("FAIL rst_dipv got=%b want=0", dip_valid); end
    total++; if (dipsw_readback !== 8'h00) begin bad++; $display("FAIL rst_dip got=%h want=00", dipsw_readback); end
    total++; if (snd_cmd !== 8'h00 || cmd_pending !== 1'b0 || cmd_overflow !== 1'b0) begin bad++; $display("FAIL rst_state got=%h/%b/%b want=00/0/0", snd_cmd, cmd_pending, cmd_overflow); end
    reset = 1'b0;
    lo = 0;
    repeat (30) begin tick(); if (!snd_nmi_n) lo++; end
    total++; if (lo !== 0) begin bad++; $display("FAIL rst_quiet got=%0d want=0", lo); end
    dip_default = 8'hA5;
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef BP_SNDCMD_FIFO_EN
    test_sequence();
    test_overflow();
    test_full_rw();
`else
    test_latch();
`endif
    test_dip_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
